// File: rtl/ex_pkg.sv
// Shared decode constants for the EX stage: operation classes, op codes,
// and the divider state encoding.
package ex_pkg;

  localparam logic [31:0] ZERO_WORD = '0;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;
  localparam logic [2:0] EXE_RES_MUL   = 3'b101;
  localparam logic [2:0] EXE_RES_JUMP  = 3'b110;
  localparam logic [2:0] EXE_RES_DIV   = 3'b111;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_JAL_OP   = 8'b0101_0000;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX operand bundle into the EX stage and its write-back / HI-LO / stall outputs.
interface ex_if;
  logic [2:0]  ex_alusel;
  logic [7:0]  ex_aluop;
  logic        ex_wreg;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [31:0] ex_link_addr;
  logic        wreg_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  modport master (
    output ex_alusel, ex_aluop, ex_wreg, ex_waddr, ex_reg1, ex_reg2, ex_link_addr,
    input  wreg_o, waddr_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  ex_alusel, ex_aluop, ex_wreg, ex_waddr, ex_reg1, ex_reg2, ex_link_addr,
    output wreg_o, waddr_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fix-up applied to the presented result.
module ex_div
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [63:0] result,
  output logic        ready
);

  div_state_t  state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] divisor, rem, quo;
  logic        neg_q, neg_r;
  logic [32:0] partial;
  logic        fits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE:    if (start) state_nxt = (op2 == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_nxt = DIV_END;
      DIV_ON:      if (cnt == 5'd31) state_nxt = DIV_END;
      DIV_END:     state_nxt = DIV_IDLE;
      default:     state_nxt = DIV_IDLE;
    endcase
  end

  // Shift the next dividend bit into the partial remainder, subtract when it fits.
  assign partial = {rem, quo[31]};
  assign fits    = partial >= {1'b0, divisor};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          cnt     <= '0;
          rem     <= '0;
          quo     <= magnitude(op1, signed_div);
          divisor <= magnitude(op2, signed_div);
          neg_q   <= signed_div & (op1[31] ^ op2[31]);
          neg_r   <= signed_div & op1[31];
        end
        DIV_BY_ZERO: begin
          rem <= '0;
          quo <= '0;
        end
        DIV_ON: begin
          rem <= fits ? 32'(partial - {1'b0, divisor}) : partial[31:0];
          quo <= {quo[30:0], fits};
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign result = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
  assign ready  = (state == DIV_END);

endmodule

// File: rtl/ex.sv
// EX stage: combinational logic/shift/arith/multiply results plus the
// multi-cycle divider, producing GPR and HI/LO write requests.
module ex
  import ex_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_if.slave bus
);

  logic [31:0] a, b;
  logic [31:0] logic_res, shift_res, arith_res, sum_add, sum_sub;
  logic        ov;
  logic        is_mult, is_div, div_ready;
  logic [63:0] mul_res, div_res;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;

  assign a = bus.ex_reg1;
  assign b = bus.ex_reg2;

  always_comb begin
    logic_res = ZERO_WORD;
    case (bus.ex_aluop)
      EXE_AND_OP: logic_res = a & b;
      EXE_OR_OP:  logic_res = a | b;
      EXE_XOR_OP: logic_res = a ^ b;
      EXE_NOR_OP: logic_res = ~(a | b);
      default:    logic_res = ZERO_WORD;
    endcase
  end

  always_comb begin
    shift_res = ZERO_WORD;
    case (bus.ex_aluop)
      EXE_SLL_OP: shift_res = b << a[4:0];
      EXE_SRL_OP: shift_res = b >> a[4:0];
      EXE_SRA_OP: shift_res = $signed(b) >>> a[4:0];
      default:    shift_res = ZERO_WORD;
    endcase
  end

  assign sum_add = a + b;
  assign sum_sub = a - b;

  always_comb begin
    arith_res = ZERO_WORD;
    ov        = 1'b0;
    case (bus.ex_aluop)
      EXE_ADD_OP: begin
        arith_res = sum_add;
        ov        = (a[31] == b[31]) && (sum_add[31] != a[31]);
      end
      EXE_ADDU_OP: arith_res = sum_add;
      EXE_SUB_OP: begin
        arith_res = sum_sub;
        ov        = (a[31] != b[31]) && (sum_sub[31] != a[31]);
      end
      EXE_SUBU_OP: arith_res = sum_sub;
      EXE_SLT_OP:  arith_res = {31'b0, $signed(a) < $signed(b)};
      EXE_SLTU_OP: arith_res = {31'b0, a < b};
      default:     arith_res = ZERO_WORD;
    endcase
    if (bus.ex_alusel != EXE_RES_ARITH) ov = 1'b0;
  end

  assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u  = {32'b0, a} * {32'b0, b};
  assign is_mult = (bus.ex_aluop == EXE_MULT_OP) || (bus.ex_aluop == EXE_MULTU_OP);
  assign mul_res = (bus.ex_aluop == EXE_MULT_OP) ? prod_s : prod_u;

  assign is_div = (bus.ex_alusel == EXE_RES_DIV) &&
                  ((bus.ex_aluop == EXE_DIV_OP) || (bus.ex_aluop == EXE_DIVU_OP));

  ex_div u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (is_div),
    .signed_div (bus.ex_aluop == EXE_DIV_OP),
    .op1        (a),
    .op2        (b),
    .result     (div_res),
    .ready      (div_ready)
  );

  always_comb begin
    bus.wreg_o     = 1'b0;
    bus.waddr_o    = '0;
    bus.wdata_o    = ZERO_WORD;
    bus.whilo_o    = 1'b0;
    bus.hi_o       = ZERO_WORD;
    bus.lo_o       = ZERO_WORD;
    bus.stallreq_o = 1'b0;
    if (rst) begin
      bus.waddr_o = bus.ex_waddr;
      bus.wreg_o  = bus.ex_wreg & ~ov;
      case (bus.ex_alusel)
        EXE_RES_LOGIC: bus.wdata_o = logic_res;
        EXE_RES_SHIFT: bus.wdata_o = shift_res;
        EXE_RES_ARITH: bus.wdata_o = arith_res;
        EXE_RES_JUMP:  bus.wdata_o = bus.ex_link_addr;
        EXE_RES_MUL: if (is_mult) begin
          bus.whilo_o = 1'b1;
          bus.hi_o    = mul_res[63:32];
          bus.lo_o    = mul_res[31:0];
        end
        EXE_RES_DIV: if (is_div) begin
          bus.stallreq_o = ~div_ready;
          bus.whilo_o    = div_ready;
          if (div_ready) begin
            bus.hi_o = div_res[63:32];
            bus.lo_o = div_res[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex.sv
// Bench for the EX stage: directed vector table, randomized ops against a
// behavioural model, and hand-written divider sequences.
module tb_ex;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_if bus ();
  ex dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] r1, r2, link;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [7:0] op,
                              input logic [31:0] r1, r2, link, input logic wreg,
                              input logic [31:0] wdata, input logic whilo,
                              input logic [31:0] hi, lo);
    vec_t v;
    v.sel = sel; v.op = op; v.r1 = r1; v.r2 = r2; v.link = link;
    v.e.wreg = wreg; v.e.wdata = wdata; v.e.whilo = whilo; v.e.hi = hi; v.e.lo = lo;
    return v;
  endfunction

  function automatic exp_t model(input logic [2:0] sel, input logic [7:0] op,
                                 input logic [31:0] r1, r2, link, input logic wreg);
    exp_t e;
    longint sa, sb, s;
    longint lim_hi, lim_lo;
    logic [63:0] p;
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    e.wreg = wreg; e.wdata = '0; e.whilo = 1'b0; e.hi = '0; e.lo = '0;
    sa = longint'($signed(r1));
    sb = longint'($signed(r2));
    p  = '0;
    if (sel == EXE_RES_LOGIC) begin
      if (op == EXE_AND_OP) e.wdata = r1 & r2;
      if (op == EXE_OR_OP)  e.wdata = r1 | r2;
      if (op == EXE_XOR_OP) e.wdata = r1 ^ r2;
      if (op == EXE_NOR_OP) e.wdata = ~(r1 | r2);
    end else if (sel == EXE_RES_SHIFT) begin
      if (op == EXE_SLL_OP) e.wdata = r2 << r1[4:0];
      if (op == EXE_SRL_OP) e.wdata = r2 >> r1[4:0];
      if (op == EXE_SRA_OP) e.wdata = 32'(sb >>> r1[4:0]);
    end else if (sel == EXE_RES_ARITH) begin
      if (op == EXE_ADD_OP || op == EXE_SUB_OP) begin
        s = (op == EXE_ADD_OP) ? sa + sb : sa - sb;
        e.wdata = 32'(s);
        if (s > lim_hi || s < lim_lo) e.wreg = 1'b0;
      end
      if (op == EXE_ADDU_OP) e.wdata = r1 + r2;
      if (op == EXE_SUBU_OP) e.wdata = r1 - r2;
      if (op == EXE_SLT_OP)  e.wdata = (sa < sb) ? 32'd1 : 32'd0;
      if (op == EXE_SLTU_OP) e.wdata = (r1 < r2) ? 32'd1 : 32'd0;
    end else if (sel == EXE_RES_MUL) begin
      if (op == EXE_MULT_OP)  p = 64'(sa * sb);
      if (op == EXE_MULTU_OP) p = {32'b0, r1} * {32'b0, r2};
      e.whilo = 1'b1;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (sel == EXE_RES_JUMP) begin
      e.wdata = link;
    end
    return e;
  endfunction

  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] x, y);
    longint sx, sy;
    logic [31:0] q, r;
    if (y == 32'd0) return '0;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = 32'(sx / sy);
      r  = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  task automatic apply(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] r1, r2,
                       input logic [31:0] link, input logic wreg, input logic [4:0] waddr);
    bus.ex_alusel    = sel;
    bus.ex_aluop     = op;
    bus.ex_reg1      = r1;
    bus.ex_reg2      = r2;
    bus.ex_link_addr = link;
    bus.ex_wreg      = wreg;
    bus.ex_waddr     = waddr;
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [4:0] waddr);
    chk({tag, ".wreg"},  64'(bus.wreg_o),  64'(e.wreg));
    chk({tag, ".waddr"}, 64'(bus.waddr_o), 64'(waddr));
    chk({tag, ".wdata"}, 64'(bus.wdata_o), 64'(e.wdata));
    chk({tag, ".whilo"}, 64'(bus.whilo_o), 64'(e.whilo));
    chk({tag, ".hilo"},  {bus.hi_o, bus.lo_o}, {e.hi, e.lo});
    chk({tag, ".stall"}, 64'(bus.stallreq_o), 64'd0);
  endtask

  // Caller sits just after a falling edge; leaves the op presented in the IDLE cycle after END.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] x, y,
                         input int exp_stall, input logic [63:0] exp_hl);
    int stalls;
    stalls = 0;
    apply(EXE_RES_DIV, op, x, y, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.stallreq_o) break;
      stalls++;
      @(negedge clk);
    end
    chk({tag, ".stall_cycles"}, 64'(stalls), 64'(exp_stall));
    chk({tag, ".whilo"}, 64'(bus.whilo_o), 64'd1);
    chk({tag, ".hilo"}, {bus.hi_o, bus.lo_o}, exp_hl);
    @(negedge clk);
    #1;
    chk({tag, ".end_one_cycle"}, {63'(bus.whilo_o), bus.stallreq_o}, 64'd1);
  endtask

  logic [10:0] rops [17] = '{
    {EXE_RES_LOGIC, EXE_AND_OP}, {EXE_RES_LOGIC, EXE_OR_OP}, {EXE_RES_LOGIC, EXE_XOR_OP},
    {EXE_RES_LOGIC, EXE_NOR_OP}, {EXE_RES_SHIFT, EXE_SLL_OP}, {EXE_RES_SHIFT, EXE_SRL_OP},
    {EXE_RES_SHIFT, EXE_SRA_OP}, {EXE_RES_ARITH, EXE_ADD_OP}, {EXE_RES_ARITH, EXE_ADDU_OP},
    {EXE_RES_ARITH, EXE_SUB_OP}, {EXE_RES_ARITH, EXE_SUBU_OP}, {EXE_RES_ARITH, EXE_SLT_OP},
    {EXE_RES_ARITH, EXE_SLTU_OP}, {EXE_RES_MUL, EXE_MULT_OP}, {EXE_RES_MUL, EXE_MULTU_OP},
    {EXE_RES_JUMP, EXE_JAL_OP}, {EXE_RES_NOP, EXE_NOP_OP}
  };

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t tbl[$];
    exp_t e;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] r1, r2, link;
    logic        wr, sgn;
    logic [4:0]  wa;

    tbl.push_back(mk(EXE_RES_ARITH, EXE_ADD_OP,  32'h7FFFFFFF, 32'h1, 0, 1'b0, 32'h80000000, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_ARITH, EXE_ADDU_OP, 32'h7FFFFFFF, 32'h1, 0, 1'b1, 32'h80000000, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_ARITH, EXE_ADD_OP,  32'h5, 32'hFFFFFFFD, 0, 1'b1, 32'h2, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_ARITH, EXE_SUB_OP,  32'h80000000, 32'h1, 0, 1'b0, 32'h7FFFFFFF, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_ARITH, EXE_SUBU_OP, 32'h0, 32'h1, 0, 1'b1, 32'hFFFFFFFF, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_SHIFT, EXE_SRA_OP,  32'h4, 32'h80000000, 0, 1'b1, 32'hF8000000, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_SHIFT, EXE_SRL_OP,  32'h4, 32'h80000000, 0, 1'b1, 32'h08000000, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_SHIFT, EXE_SLL_OP,  32'h8, 32'h12345678, 0, 1'b1, 32'h34567800, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_ARITH, EXE_SLTU_OP, 32'hFFFFFFFF, 32'h1, 0, 1'b1, 32'h0, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_ARITH, EXE_SLT_OP,  32'hFFFFFFFF, 32'h1, 0, 1'b1, 32'h1, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_MUL,   EXE_MULT_OP, 32'hFFFFFFFE, 32'h3, 0, 1'b1, 32'h0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA));
    tbl.push_back(mk(EXE_RES_MUL,   EXE_MULTU_OP, 32'hFFFFFFFE, 32'h3, 0, 1'b1, 32'h0, 1, 32'h2, 32'hFFFFFFFA));
    tbl.push_back(mk(EXE_RES_LOGIC, EXE_AND_OP,  32'hF0F0F0F0, 32'h0FF00FF0, 0, 1'b1, 32'h00F000F0, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_LOGIC, EXE_OR_OP,   32'hF0F0F0F0, 32'h0FF00FF0, 0, 1'b1, 32'hFFF0FFF0, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_LOGIC, EXE_XOR_OP,  32'hF0F0F0F0, 32'h0FF00FF0, 0, 1'b1, 32'hFF00FF00, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_LOGIC, EXE_NOR_OP,  32'hF0F0F0F0, 32'h0FF00FF0, 0, 1'b1, 32'h000F000F, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_JUMP,  EXE_JAL_OP,  32'h1, 32'h2, 32'hBFC00010, 1'b1, 32'hBFC00010, 0, 0, 0));
    tbl.push_back(mk(EXE_RES_NOP,   EXE_NOP_OP,  32'hDEADBEEF, 32'h1, 32'h44, 1'b1, 32'h0, 0, 0, 0));
    tbl.push_back(mk(3'b011,        EXE_AND_OP,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h44, 1'b1, 32'h0, 0, 0, 0));

    rst = 1'b0;
    apply(EXE_RES_ARITH, EXE_ADD_OP, 32'h1, 32'h2, 32'h0, 1'b1, 5'd7);
    #2;
    chk("reset.outputs",
        {bus.hi_o, bus.lo_o ^ bus.wdata_o, 21'(bus.waddr_o), bus.wreg_o, bus.whilo_o, bus.stallreq_o},
        64'd0);
    chk("reset.wdata", 64'(bus.wdata_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i].sel, tbl[i].op, tbl[i].r1, tbl[i].r2, tbl[i].link, 1'b1, 5'(i));
      #1;
      compare($sformatf("vec%0d", i), tbl[i].e, 5'(i));
    end

    for (int n = 0; n < 200; n++) begin
      int k;
      k    = $urandom_range(0, 16);
      sel  = rops[k][10:8];
      op   = rops[k][7:0];
      r1   = rnd_word();
      r2   = rnd_word();
      link = $urandom;
      wr   = 1'($urandom_range(0, 1));
      wa   = 5'($urandom);
      @(negedge clk);
      apply(sel, op, r1, r2, link, wr, wa);
      #1;
      e = model(sel, op, r1, r2, link, wr);
      compare($sformatf("rand%0d", n), e, wa);
    end

    @(negedge clk);
    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFFFFF9, 32'h2, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div("divu_5_0", EXE_DIVU_OP, 32'd5, 32'd0, 2, 64'd0);
    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    for (int n = 0; n < 6; n++) begin
      r1  = rnd_word();
      r2  = ($urandom_range(0, 3) == 0) ? 32'd0 : rnd_word();
      sgn = 1'($urandom_range(0, 1));
      run_div($sformatf("div_rand%0d", n), sgn ? EXE_DIV_OP : EXE_DIVU_OP, r1, r2,
              (r2 == 32'd0) ? 2 : 33, div_model(sgn, r1, r2));
    end
    apply(EXE_RES_NOP, EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);

    @(negedge clk);
    apply(EXE_RES_DIV, EXE_DIV_OP, 32'd1000, 32'd3, 32'h0, 1'b0, 5'd0);
    repeat (11) @(negedge clk);
    #1;
    chk("abort.stall_before", 64'(bus.stallreq_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort.state", 64'(dut.u_div.state), 64'(DIV_IDLE));
    chk("abort.outputs", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("abort.flags", {61'd0, bus.stallreq_o, bus.whilo_o, bus.wreg_o}, 64'd0);
    apply(EXE_RES_NOP, EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort.no_hilo", {62'd0, bus.whilo_o, bus.stallreq_o}, 64'd0);
    @(negedge clk);
    run_div("div_after_reset", EXE_DIV_OP, 32'd1000, 32'hFFFFFFFD, 33, {32'd1, 32'hFFFFFEB3});
    apply(EXE_RES_NOP, EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
